// File: rtl/cache_mshr_fill_engine_pkg.sv
// Shared cache block / MSHR entry types and the fill engine state encoding.
package cache_types_pkg;

   localparam int BLOCK_SIZE        = 4;
   localparam int WORD_W            = 32;
   localparam int ADDR_W            = 32;
   localparam int UUID_W            = 8;
   localparam int BYTE_OFF_BIT_LEN  = 2;
   localparam int BLOCK_OFF_BIT_LEN = $clog2(BLOCK_SIZE);

   typedef struct packed {
      logic                                valid;
      logic [UUID_W-1:0]                   uuid;
      logic [ADDR_W-1:0]                   block_addr;
      logic [BLOCK_SIZE-1:0]               write_status;
      logic [BLOCK_SIZE-1:0][WORD_W-1:0]   write_block;
   } mshr_reg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WB      = 2'd1,
      FILL    = 2'd2,
      INSTALL = 2'd3
   } fill_state_t;

endpackage

// File: rtl/cache_mshr_fill_engine_if.sv
// Word-wide memory request bus between the fill engine and memory.
interface cache_mshr_fill_engine_if #(
   parameter int AW = cache_types_pkg::ADDR_W,
   parameter int DW = cache_types_pkg::WORD_W
) ();

   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ready;
   logic [DW-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ready, mem_rdata
   );

endinterface

// File: rtl/cache_mshr_fill_engine_word_sequencer.sv
// Word counter and request hold shared by the writeback and fill phases.
module cache_word_sequencer #(
   parameter  int BLOCK_WORDS = cache_types_pkg::BLOCK_SIZE,
   parameter  int ADDR_W      = cache_types_pkg::ADDR_W,
   localparam int CW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              start_i,
   input  logic              active_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic              mem_ready_i,
   output logic [CW-1:0]     idx_o,
   output logic              last_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] addr_o
);

   logic [CW-1:0] k_q, k_d;

   always_comb begin
      k_d = k_q;
      if (start_i)
         k_d = '0;
      else if (active_i && mem_ready_i)
         k_d = last_o ? '0 : k_q + 1'b1;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         k_q <= '0;
      else
         k_q <= k_d;
   end

   // Address and request derive from registered state, so they hold through a stall.
   assign idx_o     = k_q;
   assign last_o    = (k_q == CW'(BLOCK_WORDS - 1));
   assign mem_req_o = active_i;
   assign addr_o    = base_addr_i
                    + (ADDR_W'(k_q) << cache_types_pkg::BYTE_OFF_BIT_LEN);

endmodule

// File: rtl/cache_mshr_fill_engine.sv
// MSHR tail consumer: victim writeback, block fill with store merge, install.
// Optional: CACHE_FILL_FULL_WRITE_BYPASS_EN skips FILL for fully written blocks.
module cache_mshr_fill_engine #(
   parameter int BLOCK_WORDS = cache_types_pkg::BLOCK_SIZE,
   parameter int WORD_W      = cache_types_pkg::WORD_W,
   parameter int ADDR_W      = cache_types_pkg::ADDR_W
) (
   input  logic                                  CLK,
   input  logic                                  nRST,
   input  cache_types_pkg::mshr_reg              mshr_in,
   output logic                                  bank_empty,
   input  logic                                  victim_valid,
   input  logic                                  victim_dirty,
   input  logic [ADDR_W-1:0]                     victim_addr,
   input  logic [BLOCK_WORDS*WORD_W-1:0]         victim_block,
   cache_mshr_fill_engine_if.master              mem,
   output logic                                  install_en,
   output logic [ADDR_W-1:0]                     install_addr,
   output logic [BLOCK_WORDS*WORD_W-1:0]         install_block,
   output logic                                  install_dirty,
   output logic [cache_types_pkg::UUID_W-1:0]    install_uuid
);

   import cache_types_pkg::*;

   localparam int CW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

   fill_state_t state_q, state_d;

   logic [ADDR_W-1:0]                  addr_q;
   logic [UUID_W-1:0]                  uuid_q;
   logic [BLOCK_WORDS-1:0]             ws_q;
   logic [BLOCK_WORDS-1:0][WORD_W-1:0] wblk_q;
   logic [ADDR_W-1:0]                  vaddr_q;
   logic [BLOCK_WORDS-1:0][WORD_W-1:0] vblk_q;
   logic [BLOCK_WORDS-1:0][WORD_W-1:0] rblk_q;
   logic [BLOCK_WORDS-1:0][WORD_W-1:0] merged;

   logic              accept;
   logic              seq_active;
   logic              wb_phase;
   logic              skip_fill;
   logic [CW-1:0]     seq_idx;
   logic              seq_last;
   logic              seq_req;
   logic [ADDR_W-1:0] seq_base;
   logic [ADDR_W-1:0] seq_addr;

`ifdef CACHE_FILL_FULL_WRITE_BYPASS_EN
   assign skip_fill = &ws_q;
`else
   assign skip_fill = 1'b0;
`endif

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      bank_empty = 1'b0;
      accept     = 1'b0;
      seq_active = 1'b0;
      wb_phase   = 1'b0;
      install_en = 1'b0;
      unique case (state_q)
         IDLE: begin
            bank_empty = 1'b1;
            if (mshr_in.valid) begin
               accept  = 1'b1;
               state_d = (victim_valid && victim_dirty) ? WB : FILL;
            end
         end
         WB: begin
            seq_active = 1'b1;
            wb_phase   = 1'b1;
            if (mem.mem_ready && seq_last)
               state_d = FILL;
         end
         FILL: begin
            if (skip_fill) begin
               state_d = INSTALL;
            end else begin
               seq_active = 1'b1;
               if (mem.mem_ready && seq_last)
                  state_d = INSTALL;
            end
         end
         INSTALL: begin
            install_en = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         addr_q  <= '0;
         uuid_q  <= '0;
         ws_q    <= '0;
         wblk_q  <= '0;
         vaddr_q <= '0;
         vblk_q  <= '0;
         rblk_q  <= '0;
      end else begin
         if (accept) begin
            addr_q  <= mshr_in.block_addr;
            uuid_q  <= mshr_in.uuid;
            ws_q    <= mshr_in.write_status;
            wblk_q  <= mshr_in.write_block;
            vaddr_q <= victim_addr;
            vblk_q  <= victim_block;
         end
         if (seq_active && !wb_phase && mem.mem_ready)
            rblk_q[seq_idx] <= mem.mem_rdata;
      end
   end

   assign seq_base = wb_phase ? vaddr_q : addr_q;

   cache_word_sequencer #(
      .BLOCK_WORDS (BLOCK_WORDS),
      .ADDR_W      (ADDR_W)
   ) u_seq (
      .CLK         (CLK),
      .nRST        (nRST),
      .start_i     (accept),
      .active_i    (seq_active),
      .base_addr_i (seq_base),
      .mem_ready_i (mem.mem_ready),
      .idx_o       (seq_idx),
      .last_o      (seq_last),
      .mem_req_o   (seq_req),
      .addr_o      (seq_addr)
   );

   assign mem.mem_req   = seq_req;
   assign mem.mem_we    = wb_phase;
   assign mem.mem_addr  = seq_active ? seq_addr : '0;
   assign mem.mem_wdata = wb_phase ? vblk_q[seq_idx] : '0;

   // Buffered store words win over fetched words, applied at install time.
   always_comb begin
      merged = '0;
      for (int k = 0; k < BLOCK_WORDS; k++)
         merged[k] = ws_q[k] ? wblk_q[k] : rblk_q[k];
   end

   assign install_addr  = install_en ? addr_q : '0;
   assign install_block = install_en ? merged : '0;
   assign install_dirty = install_en & (|ws_q);
   assign install_uuid  = install_en ? uuid_q : '0;

endmodule

// File: doc/cache_mshr_fill_engine.md
Name: cache_mshr_fill_engine

Overview:
- Bank-side consumer of the MSHR buffer tail entry.
- Accepts one miss at a time and writes back the dirty victim if required.
- Fetches the missing block word-by-word from memory, merges the buffered store data (write_status/write_block) over the fetched words, then issues a one-cycle install into the cache bank.
- Drives bank_empty back to the MSHR buffer, which advances its tail only when bank_empty is high.

Parameters:
- BLOCK_WORDS, default 4 (package BLOCK_SIZE): words per cache block.
- WORD_W, default 32: data word width.
- ADDR_W, default 32: byte address width.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- mshr_in  in  mshr_reg  tail entry of the MSHR buffer (valid, uuid, block_addr, write_status, write_block)
- bank_empty  out  1  engine idle; accepts mshr_in this cycle if valid
- victim_valid  in  1  victim way holds a valid line (sampled at accept)
- victim_dirty  in  1  victim line dirty (sampled at accept)
- victim_addr  in  ADDR_W  victim block byte address (sampled at accept)
- victim_block  in  BLOCK_WORDS*WORD_W  victim data (sampled at accept)
- mem_req  out  1  memory word request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  word byte address
- mem_wdata  out  WORD_W  write data
- mem_ready  in  1  request accepted/completed; mem_rdata valid same cycle for reads
- mem_rdata  in  WORD_W  read data
- install_en  out  1  one-cycle install strobe
- install_addr  out  ADDR_W  block address installed
- install_block  out  BLOCK_WORDS*WORD_W  merged block
- install_dirty  out  1  OR of write_status
- install_uuid  out  UUID_W  uuid of the completed miss

Behaviour:
- Reset values:
  - State IDLE; bank_empty=1.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - install_en=0, install_addr=0, install_block=0, install_dirty=0, install_uuid=0.
  - Latched entry, victim registers and word counter cleared.
- Accept: in IDLE, mshr_in.valid=1 latches the entry and victim_* in the same cycle; the buffer shifts concurrently because bank_empty=1. bank_empty is 0 in every state other than IDLE.
- State machine: IDLE -> WB (if victim_valid && victim_dirty) else FILL; WB -> FILL; FILL -> INSTALL; INSTALL -> IDLE.
- WB:
  - Issues BLOCK_WORDS writes: mem_we=1, mem_addr=victim_addr+4*k, mem_wdata=victim word k.
  - mem_req, mem_addr and mem_wdata are held stable until mem_ready.
  - Counter k advances on mem_ready; WB exits after the mem_ready for k=BLOCK_WORDS-1.
- FILL:
  - Issues reads at block_addr+4*k. On mem_ready, word k = write_status[k] ? write_block[k] : mem_rdata.
  - Words with write_status[k]=1 are still read, so memory traffic is uniform; the optional feature is the exception.
- INSTALL:
  - install_en=1 for exactly one cycle with the merged block, install_addr=block_addr, install_dirty=|write_status and install_uuid.
  - Next cycle: IDLE, bank_empty=1.
- One outstanding memory request. mem_req drops for at least zero cycles between words; back-to-back requests are allowed.
- Counter width is clog2(BLOCK_WORDS). Address adds are ADDR_W-bit with wrap; no carry checks.
- Minimum latency from accept to install_en:
  - BLOCK_WORDS+1 cycles with mem_ready tied high.
  - Add BLOCK_WORDS cycles when a writeback is needed.
- mem_ready outside WB/FILL is ignored.
- mshr_in.valid outside IDLE is ignored; the buffer holds it.
- Reset mid-operation: the transaction is abandoned, outputs return to reset values, and the latched miss is lost. The MSHR buffer is reset by the same nRST.

Optional Feature:
- Macro: CACHE_FILL_FULL_WRITE_BYPASS_EN.
- Defined: if the latched write_status is all ones, FILL is skipped (WB still occurs if needed) and INSTALL follows directly; there is no memory read traffic.
- Undefined: FILL always reads all BLOCK_WORDS words.

Decomposition:
- Shared package cache_types_pkg (existing): mshr_reg, BLOCK_SIZE, WORD_W, BLOCK_OFF_BIT_LEN, BYTE_OFF_BIT_LEN.
- New in cache_types_pkg: fill_state_t enum (IDLE, WB, FILL, INSTALL).
- One natural sub-module, cache_word_sequencer: counter plus request-hold logic shared by WB and FILL. Inputs start, base_addr, mem_ready; outputs word index, last, mem_req.

Test Plan:
1. Clean victim, write_status=0, block_addr=0x100, mem_ready=1, rdata=0xA0..0xA3 -> reads at 0x100,0x104,0x108,0x10C. install_en on cycle 5 after accept with block {A3,A2,A1,A0}, install_dirty=0, bank_empty=1 the next cycle.
2. Dirty victim at 0x200 with data {D3..D0}, miss at 0x100 -> 4 writes to 0x200..0x20C carrying D0..D3, then 4 reads; install_en at cycle 9.
3. write_status=4'b0101, write_block[0]=0x11, write_block[2]=0x33, rdata=0xA* -> installed {A3,33,A1,11}, install_dirty=1.
4. mem_ready withheld 3 cycles on word 1 -> mem_req, mem_addr and mem_wdata stay constant through the stall; no word skipped or duplicated.
5. mshr_in.valid held high during FILL -> bank_empty=0 and no second accept; the entry is accepted in the IDLE cycle after install.
6. nRST asserted mid-FILL -> all outputs at reset values immediately, bank_empty=1. With CACHE_FILL_FULL_WRITE_BYPASS_EN and write_status=4'hF: no mem_req, install_en 2 cycles after accept.
